// File: rtl/interval_meter_pkg.sv
// Shared constants for the interval meter: FSM state encoding and default counter width.
package interval_meter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; rise is high in the cycle where in=1 and the previous sample was 0.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/interval_meter.sv
// Measures the cycle count between an accepted start and the next stop rising edge,
// and presents it on a valid/ready result port.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_count,
  output logic             result_overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] counter;
  logic             stop_rise;
  logic             saturated;

  // The stop history tracks stop in every state, so a stop already high on entry to RUN must fall first.
  rise_detect u_stop_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (stop),
    .rise (stop_rise)
  );

  assign saturated = (counter == CNT_MAX);

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start)        next_state = ST_RUN;
      ST_RUN:  if (stop_rise)    next_state = ST_HOLD;
      ST_HOLD: if (result_ready) next_state = start ? ST_RUN : ST_IDLE;
      default:                   next_state = ST_IDLE;
    endcase
    if (clear) next_state = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      counter         <= '0;
      result_count    <= '0;
      result_overflow <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= (next_state == ST_RUN);
      result_valid <= (next_state == ST_HOLD);

      if (clear) begin
        counter <= '0;
      end else if (next_state == ST_RUN && state != ST_RUN) begin
        counter <= '0;
      end else if (state == ST_RUN && !stop_rise && !saturated) begin
        counter <= counter + 1'b1;
      end

      // Capture on the stop edge: counter+1 if representable, otherwise pinned to all ones.
      if (!clear && state == ST_RUN && stop_rise) begin
        result_count    <= saturated ? CNT_MAX : counter + 1'b1;
        result_overflow <= saturated;
      end
    end
  end

endmodule

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter: a 16-bit and a 4-bit instance share stimulus.
module tb_interval_meter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic result_ready = 1'b1;

  logic        busy, result_valid, result_overflow;
  logic [15:0] result_count;
  logic        busy4, valid4, ovf4;
  logic [3:0]  count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interval_meter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count), .result_overflow(result_overflow)
  );

  interval_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .busy(busy4), .result_valid(valid4), .result_ready(result_ready),
    .result_count(count4), .result_overflow(ovf4)
  );

  // Timer stand-in: 1-cycle start accepted at edge S, stop rises sampled at edge S+n.
  // Returns at the negedge just after edge S+n.
  task automatic pulse_measure(input int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (n - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, result_valid, result_overflow, result_count} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%0b valid=%0b ovf=%0b count=%0d required all 0",
               busy, result_valid, result_overflow, result_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timer_101();
    result_ready = 1'b1;
    pulse_measure(101);
    checks++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t101_valid: got valid=%0b busy=%0b required valid=1 busy=0", result_valid, busy);
    end
    checks++;
    if (result_count !== 16'd101 || result_overflow !== 1'b0) begin
      failures++;
      $display("FAIL t101_count: got %0d ovf=%0b required 101 ovf=0", result_count, result_overflow);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL t101_valid_one_cycle: got valid=%0b required 0", result_valid);
    end
  endtask

  task automatic test_timer_900();
    for (int k = 0; k < 2; k++) begin
      pulse_measure(900);
      checks++;
      if (result_valid !== 1'b1 || result_count !== 16'd900 || result_overflow !== 1'b0) begin
        failures++;
        $display("FAIL t900_run%0d: got valid=%0b count=%0d ovf=%0b required 1/900/0",
                 k, result_valid, result_count, result_overflow);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_min_interval();
    pulse_measure(1);
    checks++;
    if (result_valid !== 1'b1 || result_count !== 16'd1) begin
      failures++;
      $display("FAIL min_interval: got valid=%0b count=%0d required 1/1", result_valid, result_count);
    end
    repeat (3) @(negedge clk);
    // Stop rises on the start edge itself: ignored, and stays high into RUN.
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_on_start_edge: got busy=%0b valid=%0b required 1/0", busy, result_valid);
    end
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_count !== 16'd5) begin
      failures++;
      $display("FAIL stop_after_ignored: got valid=%0b count=%0d required 1/5", result_valid, result_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    pulse_measure(20);
    checks++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1 || valid4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_over20: got count=%0d ovf=%0b valid=%0b required 15/1/1", count4, ovf4, valid4);
    end
    checks++;
    if (result_count !== 16'd20 || result_overflow !== 1'b0) begin
      failures++;
      $display("FAIL w16_20: got count=%0d ovf=%0b required 20/0", result_count, result_overflow);
    end
    repeat (3) @(negedge clk);
    pulse_measure(15);
    checks++;
    if (count4 !== 4'd15 || ovf4 !== 1'b0 || valid4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_exact15: got count=%0d ovf=%0b valid=%0b required 15/0/1", count4, ovf4, valid4);
    end
    repeat (3) @(negedge clk);
    pulse_measure(16);
    checks++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_16: got count=%0d ovf=%0b required 15/1", count4, ovf4);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    result_ready = 1'b0;
    pulse_measure(42);
    for (int i = 0; i < 30; i++) begin
      stop  = i[0];
      start = (i % 3 == 0);
      @(negedge clk);
      checks++;
      if (result_count !== 16'd42 || result_valid !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got count=%0d valid=%0b busy=%0b required 42/1/0",
                 i, result_count, result_valid, busy);
      end
    end
    stop = 1'b0; start = 1'b1; result_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handover: got valid=%0b busy=%0b required 0/1", result_valid, busy);
    end
    repeat (6) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_count !== 16'd7) begin
      failures++;
      $display("FAIL b2b_second: got valid=%0b count=%0d required 1/7", result_valid, result_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_in_run: got busy=%0b valid=%0b required 0/0", busy, result_valid);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_after_clear: got busy=%0b valid=%0b required 0/0", busy, result_valid);
    end
    clear = 1'b1; start = 1'b1;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_over_start: got busy=%0b required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    result_ready = 1'b0;
    pulse_measure(3);
    checks++;
    if (result_valid !== 1'b1 || result_count !== 16'd3) begin
      failures++;
      $display("FAIL pre_reset_hold: got valid=%0b count=%0d required 1/3", result_valid, result_count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, result_valid, result_overflow, result_count} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset_hold: got busy=%0b valid=%0b ovf=%0b count=%0d required all 0",
               busy, result_valid, result_overflow, result_count);
    end
    #1 rst = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_timer_101();
    test_timer_900();
    test_min_interval();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interval_meter.md
Name: interval_meter

Overview:
- Measures the clock-cycle interval between a start event and a stop event and reports it over a valid/ready result port.
- It is the measuring counterpart of the timer block: the timer turns a count into a pulse, this block turns a pulse interval back into a count.
- Wiring a timer's start to `start` and its done to `stop` must read back exactly the timer's STOP_COUNT.
- Used in benches and in-system as a self-check and latency monitor.

Parameters:
- WIDTH, 16, width of the interval counter and result; maximum reportable interval is 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous abort; returns the block to IDLE and discards any measurement or held result.
- start  input  1  level; accepted when the block is ready for a new measurement.
- stop  input  1  measurement ends on its rising edge (stop=1 and the previous-cycle stop=0).
- busy  output  1  high while a measurement is running (RUN state).
- result_valid  output  1  high while a result is held (HOLD state).
- result_ready  input  1  consumer accepts the result when result_valid and result_ready are both 1 on a clock edge.
- result_count  output  WIDTH  measured interval in cycles; stable while result_valid=1.
- result_overflow  output  1  interval exceeded 2^WIDTH-1; result_count is then all ones.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, result_valid=0, result_count=0, result_overflow=0.
  - internal counter=0, stop history register=0.
- Definition of the measurement:
  - Edge S is the clock edge on which start is accepted.
  - Edge E is the first later edge on which a stop rising edge is sampled.
  - result_count=E-S.
  - Example: start accepted at cycle 10, stop first rises at the edge of cycle 111 -> result 101.
- IDLE:
  - start=1 -> RUN, counter<=0.
  - stop is ignored.
  - The stop history register always tracks stop, in every state.
- RUN:
  - busy=1.
  - Each edge without a stop rising edge: counter increments, saturating at 2^WIDTH-1; the overflow flag sets when an increment is attempted at saturation.
  - Stop rising edge, with counter+1 <= 2^WIDTH-1:
    - result_count<=counter+1, result_overflow<=0, state -> HOLD.
  - Stop rising edge, saturated:
    - result_count<=all ones, result_overflow<=1, state -> HOLD.
  - start is ignored (no retrigger).
- HOLD:
  - result_valid=1; result_count and result_overflow hold their values.
  - result_ready=1, start=0 -> IDLE on that edge.
  - result_ready=1, start=1 -> RUN directly on that edge (back-to-back measurement, counter<=0). The new S is that edge.
  - result_ready=0 -> stay in HOLD; start and stop are ignored.
- Stop rising edge on the same edge start is accepted: ignored, since the block is not yet in RUN. Minimum reportable interval is 1.
- A stop that is already high when RUN is entered does not end the measurement; it must fall and rise again.
- clear=1 (any state):
  - Takes priority over start, stop and result_ready.
  - Next state IDLE, result_valid=0, busy=0, counter=0.
  - result_count and result_overflow keep their last values and are not meaningful.
- rst asserted mid-measurement or in HOLD: immediate return to reset values; the held result is lost.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package `interval_meter_pkg`:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2 (2'd3 is illegal and recovers to IDLE).
  - default WIDTH constant.
- One natural sub-module: `rise_detect` (1-bit registered edge detector with async active-high reset, output = in & ~in_q). It is reusable for other event-driven blocks.
- The counter and the FSM stay in the top module.

Test Plan:
- Timer with STOP_COUNT=101 driven by a 1-cycle start; its done goes to `stop`, result_ready=1 -> result_count=101, overflow=0, result_valid high exactly 1 cycle.
- Same setup with a STOP_COUNT=900 timer, run twice non-consecutively -> result_count=900 both times.
- Start accepted at edge S, stop rises at edge S+1 -> result_count=1. Stop rising on edge S itself -> ignored; stop rises again at S+5 -> result_count=5.
- WIDTH=4, stop rises 20 cycles after start -> result_count=15, overflow=1. Then WIDTH=4 with stop at 15 cycles -> result_count=15, overflow=0.
- result_ready held 0 for 30 cycles after a result of 42, with stop toggling and start pulsing -> result_count stays 42, no state change. Then result_ready=1 with start=1 -> result_valid drops and busy=1 on the same edge; next measurement is correct.
- clear asserted in RUN at cycle 50 after start -> busy=0 on the next edge and no result_valid. Reset asserted mid-HOLD -> all outputs return to 0 asynchronously.
